// File: rtl/demond_accum.sv
// demond_accum: single-cycle ADD/SUB/ACC/LOAD unit with optional saturation, feeding a
// result FIFO of {result, carry/borrow flag} entries.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   operation handshake (in_ready = FIFO not full, low in reset)
//   a, b                  unsigned operands (WIDTH bits)
//   mode                  00 ADD a+b, 01 SUB a-b, 10 ACC acc+a, 11 LOAD acc<=a
//   sat_en                saturate instead of wrapping
//   out_valid / out_ready result handshake (out_valid = FIFO not empty)
//   out_data, out_flag    FIFO head result and carry/borrow flag (0 when empty)
//   count                 FIFO occupancy
module demond_accum #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [WIDTH-1:0]          a,
   input  logic [WIDTH-1:0]          b,
   input  logic [1:0]                mode,
   input  logic                      sat_en,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic                      out_flag,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   localparam logic [1:0] MODE_ADD  = 2'b00;
   localparam logic [1:0] MODE_SUB  = 2'b01;
   localparam logic [1:0] MODE_ACC  = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   logic [WIDTH-1:0] r_acc;
   logic [WIDTH:0]   r_mem [DEPTH];
   logic [PW-1:0]    r_wptr;
   logic [PW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;

   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_result;
   logic             w_flag;
   logic             w_push;
   logic             w_pop;

   // Operands are zero-extended so bit WIDTH of the sum is the carry-out, and for
   // subtraction it is set exactly when a < b (the borrow).
   always_comb begin
      w_sum    = '0;
      w_result = '0;
      w_flag   = 1'b0;
      case (mode)
         MODE_ADD: begin
            w_sum    = {1'b0, a} + {1'b0, b};
            w_flag   = w_sum[WIDTH];
            w_result = (sat_en && w_flag) ? '1 : w_sum[WIDTH-1:0];
         end
         MODE_SUB: begin
            w_sum    = {1'b0, a} - {1'b0, b};
            w_flag   = w_sum[WIDTH];
            w_result = (sat_en && w_flag) ? '0 : w_sum[WIDTH-1:0];
         end
         MODE_ACC: begin
            w_sum    = {1'b0, r_acc} + {1'b0, a};
            w_flag   = w_sum[WIDTH];
            w_result = (sat_en && w_flag) ? '1 : w_sum[WIDTH-1:0];
         end
         MODE_LOAD: begin
            w_result = a;
         end
         default: begin
            w_result = '0;
         end
      endcase
   end

   // Full blocks acceptance even when a pop happens in the same cycle.
   assign in_ready  = ~rst && (r_count < CW'(DEPTH));
   assign out_valid = (r_count != '0);
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;

   assign out_data  = out_valid ? r_mem[r_rptr][WIDTH-1:0] : '0;
   assign out_flag  = out_valid ? r_mem[r_rptr][WIDTH]     : 1'b0;
   assign count     = r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc <= '0;
      end else if (w_push) begin
         if (mode == MODE_ACC) begin
            r_acc <= w_result;
         end else if (mode == MODE_LOAD) begin
            r_acc <= a;
         end
      end
   end

   // Storage needs no reset: entries are only visible while count says they are valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= {w_flag, w_result};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + PW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_demond_accum.sv
module tb_demond_accum;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic [1:0] mode;
   logic       sat_en;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_flag;
   logic [2:0] count;

   int checks = 0;
   int errors = 0;

   // Reference model: queue of {flag, data} entries plus the accumulator value.
   logic [8:0] mq[$];
   int         macc;

   demond_accum #(.WIDTH(8), .DEPTH(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .mode(mode), .sat_en(sat_en),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_flag(out_flag), .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [8:0] model_op(input logic [1:0] m, input int x, input int y,
                                           input int ac, input bit s);
      int r;
      bit f;
      r = 0;
      f = 1'b0;
      case (m)
         2'd0: begin r = x + y;  f = (r > 255); if (f) r = s ? 255 : r - 256; end
         2'd1: begin r = x - y;  f = (x < y);   if (f) r = s ? 0 : r + 256; end
         2'd2: begin r = ac + x; f = (r > 255); if (f) r = s ? 255 : r - 256; end
         default: begin r = x; f = 1'b0; end
      endcase
      return {f, r[7:0]};
   endfunction

   // Advance one clock edge, updating the model from the inputs seen at that edge.
   task automatic step();
      bit         push;
      bit         pop;
      logic [8:0] e;
      int         ca;
      logic [1:0] cm;
      push = in_valid && !rst && (mq.size() < 4);
      pop  = !rst && (mq.size() != 0) && out_ready;
      e    = model_op(mode, int'(a), int'(b), macc, sat_en);
      ca   = int'(a);
      cm   = mode;
      @(posedge clk);
      if (pop) void'(mq.pop_front());
      if (push) begin
         mq.push_back(e);
         if (cm == 2'd2) macc = int'(e[7:0]);
         else if (cm == 2'd3) macc = ca;
      end
      #1;
   endtask

   task automatic set_op(input bit v, input logic [1:0] m, input int x, input int y,
                         input bit s);
      in_valid = v;
      mode     = m;
      a        = x[7:0];
      b        = y[7:0];
      sat_en   = s;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; mode = '0; sat_en = 0;
      mq.delete(); macc = 0;
      repeat (2) @(posedge clk);
      #2;
      checks++; if (in_ready !== 1'b0) begin errors++;
         $display("FAIL reset_in_ready got %0b want 0", in_ready); end
      checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin errors++;
         $display("FAIL reset_empty got valid=%0b count=%0d want 0/0", out_valid, count); end
      checks++; if (out_data !== 8'd0 || out_flag !== 1'b0) begin errors++;
         $display("FAIL reset_outputs got %0d/%0b want 0/0", out_data, out_flag); end
      rst = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++;
         $display("FAIL post_reset_ready got %0b want 1", in_ready); end
      step();
   endtask

   task automatic test_add_sub();
      int exp_d[5] = '{44, 255, 252, 0, 4};
      bit exp_f[5] = '{1, 1, 1, 1, 0};
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         case (i)
            0: set_op(1, 2'd0, 200, 100, 0);
            1: set_op(1, 2'd0, 200, 100, 1);
            2: set_op(1, 2'd1, 5, 9, 0);
            3: set_op(1, 2'd1, 5, 9, 1);
            default: set_op(1, 2'd1, 9, 5, 0);
         endcase
         if (i == 0) begin
            checks++; if (out_valid !== 1'b0) begin errors++;
               $display("FAIL no_bypass got valid=%0b want 0", out_valid); end
         end
         step();
         checks++;
         if (out_valid !== 1'b1 || out_data !== exp_d[i][7:0] || out_flag !== exp_f[i]) begin
            errors++;
            $display("FAIL add_sub_%0d got v=%0b %0d/%0b want 1 %0d/%0b", i, out_valid,
                     out_data, out_flag, exp_d[i], exp_f[i]);
         end
      end
      in_valid = 1'b0;
      step();
      checks++; if (out_valid !== 1'b0 || out_data !== 8'd0 || out_flag !== 1'b0) begin
         errors++;
         $display("FAIL empty_outputs got v=%0b %0d/%0b want 0 0/0", out_valid, out_data,
                  out_flag);
      end
   endtask

   task automatic test_acc_chain();
      int exp_d[4] = '{250, 253, 7, 7};
      bit exp_f[4] = '{0, 0, 1, 0};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         case (i)
            0: set_op(1, 2'd3, 250, 0, 0);
            1: set_op(1, 2'd2, 3, 0, 0);
            2: set_op(1, 2'd2, 10, 0, 0);
            default: set_op(1, 2'd2, 0, 0, 0);
         endcase
         step();
         checks++;
         if (out_data !== exp_d[i][7:0] || out_flag !== exp_f[i] || count !== 3'd1) begin
            errors++;
            $display("FAIL acc_chain_%0d got %0d/%0b cnt=%0d want %0d/%0b cnt=1", i, out_data,
                     out_flag, count, exp_d[i], exp_f[i]);
         end
      end
      in_valid = 1'b0;
      step();
   endtask

   task automatic test_full_stall();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         set_op(1, 2'd0, i * 10 + 1, i, 0);
         checks++; if (in_ready !== (i < 4)) begin errors++;
            $display("FAIL fill_ready_%0d got %0b want %0b", i, in_ready, (i < 4)); end
         step();
      end
      checks++; if (count !== 3'd4 || in_ready !== 1'b0) begin errors++;
         $display("FAIL full got cnt=%0d rdy=%0b want 4/0", count, in_ready); end
      in_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checks++; if (out_data !== 8'd1) begin errors++;
            $display("FAIL stall_hold got %0d want 1", out_data); end
         step();
      end
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         checks++; if (out_valid !== 1'b1 || out_data !== 8'(k * 11 + 1)) begin errors++;
            $display("FAIL drain_%0d got v=%0b %0d want 1 %0d", k, out_valid, out_data,
                     k * 11 + 1); end
         step();
      end
      checks++; if (count !== 3'd0) begin errors++;
         $display("FAIL drained got cnt=%0d want 0", count); end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      for (int j = 0; j < 2; j++) begin
         set_op(1, 2'd0, 20 + j, 0, 0);
         step();
      end
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         set_op(1, 2'd0, 22 + k, 0, 0);
         step();
         checks++; if (count !== 3'd2 || out_data !== 8'(21 + k)) begin errors++;
            $display("FAIL push_pop_%0d got cnt=%0d %0d want 2 %0d", k, count, out_data,
                     21 + k); end
      end
      in_valid = 1'b0;
      repeat (2) step();
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      set_op(1, 2'd3, 99, 0, 0); step();
      set_op(1, 2'd0, 1, 2, 0); step();
      step();
      checks++; if (count !== 3'd3) begin errors++;
         $display("FAIL pre_reset_count got %0d want 3", count); end
      #2 rst = 1'b1;
      #1;
      mq.delete(); macc = 0;
      checks++; if (out_valid !== 1'b0 || count !== 3'd0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL async_reset got v=%0b cnt=%0d rdy=%0b want 0/0/0", out_valid, count,
                  in_ready);
      end
      #2 rst = 1'b0;
      out_ready = 1'b1;
      set_op(1, 2'd2, 1, 0, 0);
      step();
      checks++; if (out_data !== 8'd1 || out_flag !== 1'b0 || count !== 3'd1) begin errors++;
         $display("FAIL acc_after_reset got %0d/%0b cnt=%0d want 1/0 cnt=1", out_data,
                  out_flag, count); end
      in_valid = 1'b0;
      step();
   endtask

   task automatic test_random();
      logic [8:0] head;
      for (int n = 0; n < 400; n++) begin
         set_op(bit'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                bit'($urandom_range(0, 1)));
         out_ready = ($urandom_range(0, 2) != 0);
         step();
         head = (mq.size() != 0) ? mq[0] : 9'd0;
         checks++;
         if (count !== 3'(mq.size()) || out_valid !== (mq.size() != 0) ||
             in_ready !== (mq.size() < 4) || out_data !== head[7:0] ||
             out_flag !== head[8]) begin
            errors++;
            $display("FAIL random_%0d got cnt=%0d v=%0b r=%0b %0d/%0b want cnt=%0d %0d/%0b",
                     n, count, out_valid, in_ready, out_data, out_flag, mq.size(),
                     head[7:0], head[8]);
         end
      end
      in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_acc_chain();
      test_full_stall();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
